// File: rtl/alu_sel_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_sel_seq
// Brief   : Bit-serial operand selector. Drives one-hot select lines to an
//           external 4:1 priority mux, walks bit_idx LSB first, and assembles
//           the returned mux output y_in into a WIDTH-bit result delivered
//           over a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module alu_sel_seq #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 op,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic                       abort,
  output logic                       s1,
  output logic                       s2,
  output logic                       s3,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  input  logic                       y_in,
  output logic [WIDTH-1:0]           result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy
);

  localparam int                 IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_sel;          // {s3, s2, s1}
  logic [IDX_W-1:0]   r_bit_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_result_valid;

  // Latched opcode is kept in its decoded one-hot select form; at most one
  // select is ever high, and op 00 (input A) is the all-low default.
  function automatic logic [2:0] f_encode_sel(input logic [1:0] f_op);
    case (f_op)
      2'b00:   f_encode_sel = 3'b000;
      2'b01:   f_encode_sel = 3'b001;
      2'b10:   f_encode_sel = 3'b010;
      default: f_encode_sel = 3'b100;
    endcase
  endfunction

  // Main control FSM: accept, serial capture, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sel          <= 3'b000;
      r_bit_idx      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // abort blocks acceptance in the same cycle
          if (op_valid && !abort) begin
            r_sel     <= f_encode_sel(op);
            r_result  <= '0;
            r_bit_idx <= '0;
            r_state   <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            r_sel          <= 3'b000;
            r_bit_idx      <= '0;
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end else begin
            r_result[r_bit_idx] <= y_in;
            if (r_bit_idx == C_LAST_IDX) begin
              r_bit_idx      <= '0;
              r_sel          <= 3'b000;
              r_result_valid <= 1'b1;
              r_state        <= DONE;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end

        DONE: begin
          // abort beats a simultaneous transfer; either way valid drops
          if (abort || result_ready) begin
            r_result_valid <= 1'b0;
            r_sel          <= 3'b000;
            r_bit_idx      <= '0;
            r_state        <= IDLE;
          end
        end

        default: begin
          r_sel          <= 3'b000;
          r_bit_idx      <= '0;
          r_result_valid <= 1'b0;
          r_state        <= IDLE;
        end
      endcase
    end
  end

  // Output mapping; ready and busy are pure decodes of the state register.
  always_comb begin
    op_ready     = (r_state == IDLE);
    busy         = (r_state != IDLE);
    s1           = r_sel[0];
    s2           = r_sel[1];
    s3           = r_sel[2];
    bit_idx      = r_bit_idx;
    result       = r_result;
    result_valid = r_result_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sel_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_sel_seq
// Brief   : Directed self-checking bench for alu_sel_seq (WIDTH=8) with a
//           behavioural 4:1 priority mux closing the y_in loop.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_sel_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       op;
  logic             op_valid;
  logic             op_ready;
  logic             abort;
  logic             s1, s2, s3;
  logic [2:0]       bit_idx;
  logic             y_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  logic [WIDTH-1:0] a_val, b_val, c_val, d_val;
  logic [2:0]       w_sel;

  int n_checks;
  int n_errors;

  alu_sel_seq #(.WIDTH(WIDTH)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .abort        (abort),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .bit_idx      (bit_idx),
    .y_in         (y_in),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_sel = {s3, s2, s1};

  // Downstream priority mux: s1 > s2 > s3 > default A.
  always_comb begin
    if (s1)      y_in = b_val[bit_idx];
    else if (s2) y_in = c_val[bit_idx];
    else if (s3) y_in = d_val[bit_idx];
    else         y_in = a_val[bit_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] code);
    op       = code;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  // Waits in RUN for the full serial phase, checking selects and the index.
  task automatic run_bits(input string tag, input logic [2:0] exp_sel);
    for (int i = 0; i < WIDTH; i++) begin
      check({tag, "_sel"}, 32'(w_sel), 32'(exp_sel));
      check({tag, "_idx"}, 32'(bit_idx), 32'(i));
      check({tag, "_rv_low"}, 32'(result_valid), 32'd0);
      step();
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    op           = 2'b00;
    op_valid     = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b0;
    a_val = 8'hFF; b_val = 8'hA5; c_val = 8'h01; d_val = 8'h3C;

    // Reset state
    #12;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_sel", 32'(w_sel), 32'd0);
    check("rst_idx", 32'(bit_idx), 32'd0);
    rst_n = 1'b1;
    #2;

    // op=01 selects B=0xA5; result_valid 8 edges after accept
    step();
    accept(2'b01);
    check("b_busy", 32'(busy), 32'd1);
    check("b_op_ready", 32'(op_ready), 32'd0);
    run_bits("b", 3'b001);
    check("b_rv", 32'(result_valid), 32'd1);
    check("b_result", 32'(result), 32'hA5);
    check("b_sel_done", 32'(w_sel), 32'd0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("b_rv_drop", 32'(result_valid), 32'd0);
    check("b_idle_ready", 32'(op_ready), 32'd1);
    step();
    check("b_result_hold", 32'(result), 32'hA5);

    // op=11 selects D=0x3C; consumer stalls 5 cycles, op_valid pulses ignored
    accept(2'b11);
    run_bits("d", 3'b100);
    for (int i = 0; i < 5; i++) begin
      op       = 2'b01;
      op_valid = (i % 2 == 0);
      check("d_stall_result", 32'(result), 32'h3C);
      check("d_stall_rv", 32'(result_valid), 32'd1);
      check("d_stall_op_ready", 32'(op_ready), 32'd0);
      step();
    end
    op_valid     = 1'b0;
    check("d_stall_busy", 32'(busy), 32'd1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("d_rv_drop", 32'(result_valid), 32'd0);

    // Back-to-back: op=00 (A=0xFF) then op=10 (C=0x01) as soon as ready
    accept(2'b00);
    run_bits("a", 3'b000);
    check("a_result", 32'(result), 32'hFF);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("a_op_ready", 32'(op_ready), 32'd1);
    accept(2'b10);
    check("c_result_cleared", 32'(result), 32'd0);
    run_bits("c", 3'b010);
    check("c_rv", 32'(result_valid), 32'd1);
    check("c_result", 32'(result), 32'h01);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // abort in RUN at bit_idx=3
    accept(2'b01);
    for (int i = 0; i < 3; i++) step();
    check("ab_run_idx", 32'(bit_idx), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_run_busy", 32'(busy), 32'd0);
    check("ab_run_sel", 32'(w_sel), 32'd0);
    check("ab_run_idx0", 32'(bit_idx), 32'd0);
    check("ab_run_op_ready", 32'(op_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("ab_run_no_rv", 32'(result_valid), 32'd0);
      step();
    end

    // abort in IDLE beats op_valid
    op       = 2'b11;
    op_valid = 1'b1;
    abort    = 1'b1;
    step();
    op_valid = 1'b0;
    abort    = 1'b0;
    check("ab_idle_busy", 32'(busy), 32'd0);
    check("ab_idle_sel", 32'(w_sel), 32'd0);

    // abort together with result_ready in DONE
    accept(2'b10);
    run_bits("abd", 3'b010);
    check("abd_rv", 32'(result_valid), 32'd1);
    abort        = 1'b1;
    result_ready = 1'b1;
    step();
    abort        = 1'b0;
    result_ready = 1'b0;
    check("abd_rv_drop", 32'(result_valid), 32'd0);
    check("abd_busy", 32'(busy), 32'd0);
    step();
    check("abd_stay_idle", 32'(op_ready), 32'd1);

    // async reset at bit_idx=5, then immediate new op
    accept(2'b11);
    for (int i = 0; i < 5; i++) step();
    check("rr_idx5", 32'(bit_idx), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_sel", 32'(w_sel), 32'd0);
    check("rr_idx", 32'(bit_idx), 32'd0);
    check("rr_result", 32'(result), 32'd0);
    check("rr_rv", 32'(result_valid), 32'd0);
    check("rr_op_ready", 32'(op_ready), 32'd1);
    step();
    rst_n = 1'b1;
    c_val = 8'h5A;
    accept(2'b10);
    check("rr_accept_busy", 32'(busy), 32'd1);
    run_bits("rr", 3'b010);
    check("rr_result_new", 32'(result), 32'h5A);
    check("rr_rv_new", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("rr_final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
